// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
// Contents: FSM state enum, ALU select codes, counter width helper.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    localparam logic [3:0] ALU_SEL_ADD = 4'b0010;
    localparam logic [3:0] ALU_SEL_AND = 4'b0000;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_step_counter.sv
// Loadable down-counter tracking remaining shift-add steps.
// Ports: clk, rst (async, active high), load_i (load N), dec_i (count down),
//        clr_i (force 0), cnt_o (current count), is_last_o (count == 1).
module mul_step_counter
    import mul_seq_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          is_last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(N);
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_mul_sequencer.sv
// Unsigned NxN->2N radix-2 shift-add multiplier borrowing the external ALU adder.
// Ports: req_* (operand handshake), resp_* (product handshake), alu_* (ALU
// operands/select/ownership out, sum/carry in). Optional: MULSEQ_EARLY_EXIT_EN
// finishes early once the remaining multiplier bits are all zero.
module alu_mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [N-1:0]   req_a_i,
    input  logic [N-1:0]   req_b_i,
    output logic           resp_valid_o,
    input  logic           resp_ready_i,
    output logic [2*N-1:0] resp_prod_o,
    output logic [N-1:0]   alu_a_o,
    output logic [N-1:0]   alu_b_o,
    output logic [3:0]     alu_sel_o,
    output logic           alu_busy_o,
    input  logic [N-1:0]   alu_result_i,
    input  logic           alu_carry_i
);

    localparam int CW = cnt_width(N);

    mul_state_e    state_q, state_d;
    logic [N-1:0]  acc_hi_q, acc_hi_d;
    logic [N-1:0]  acc_lo_q, acc_lo_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplr_q, mplr_d;

    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_clr;
    logic [CW-1:0] cnt;
    logic          cnt_last;
    logic          early_exit;
    logic [2*N-1:0] acc_shr;

    mul_step_counter #(.N(N), .CW(CW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .dec_i     (cnt_dec),
        .clr_i     (cnt_clr),
        .cnt_o     (cnt),
        .is_last_o (cnt_last)
    );

`ifdef MULSEQ_EARLY_EXIT_EN
    // Remaining steps would only add zero; collapse them into one shift.
    assign early_exit = (state_q == ST_RUN) && (mplr_q == '0);
`else
    assign early_exit = 1'b0;
`endif

    assign acc_shr = {acc_hi_q, acc_lo_q} >> cnt;

    always_comb begin
        state_d      = state_q;
        acc_hi_d     = acc_hi_q;
        acc_lo_d     = acc_lo_q;
        mcand_d      = mcand_q;
        mplr_d       = mplr_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_clr      = 1'b0;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        alu_a_o      = '0;
        alu_b_o      = '0;
        alu_sel_o    = ALU_SEL_AND;
        alu_busy_o   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    mcand_d  = req_a_i;
                    mplr_d   = req_b_i;
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    cnt_load = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (early_exit) begin
                    {acc_hi_d, acc_lo_d} = acc_shr;
                    cnt_clr = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    alu_busy_o = 1'b1;
                    alu_sel_o  = ALU_SEL_ADD;
                    alu_a_o    = acc_hi_q;
                    alu_b_o    = mplr_q[0] ? mcand_q : '0;
                    // Sum plus carry becomes the new top; the whole
                    // accumulator shifts right by one.
                    {acc_hi_d, acc_lo_d} =
                        {alu_carry_i, alu_result_i, acc_lo_q[N-1:1]};
                    mplr_d  = mplr_q >> 1;
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
        end
    end

    assign resp_prod_o = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer at N=8 with a behavioural ALU adder.
// Latency counts the accept cycle as 0; resp_valid is expected in cycle 9.
module tb_alu_mul_sequencer;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [N-1:0]   req_a = '0;
    logic [N-1:0]   req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [2*N-1:0] resp_prod;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [3:0]     alu_sel;
    logic           alu_busy;
    logic [N-1:0]   alu_result;
    logic           alu_carry;
    logic [N:0]     alu_sum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = alu_sum[N-1:0];
    assign alu_carry  = alu_sum[N];

    alu_mul_sequencer #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_prod_o  (resp_prod),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_sel_o    (alu_sel),
        .alu_busy_o   (alu_busy),
        .alu_result_i (alu_result),
        .alu_carry_i  (alu_carry)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and waits (bounded) for resp_valid.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int adds, output int carries);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        adds = 0;
        carries = 0;
        while (!resp_valid && lat < 40) begin
            if (alu_busy && alu_sel === 4'b0010) adds++;
            if (alu_busy && alu_carry) carries++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({req_ready, resp_valid, alu_busy, alu_sel, resp_prod}
            !== {1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b sel=%b prod=%h need 1 0 0 0000 0000",
                     req_ready, resp_valid, alu_busy, alu_sel, resp_prod);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, adds, car;
        int exp_lat, exp_adds;
`ifdef MULSEQ_EARLY_EXIT_EN
        exp_lat = 6; exp_adds = 4;
`else
        exp_lat = 9; exp_adds = 8;
`endif
        resp_ready = 1'b1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ready: got %b need 1", req_ready);
        end
        run_op(8'd13, 8'd11, lat, adds, car);
        n_cmp++;
        if (resp_prod !== 16'h008F) begin
            n_err++;
            $display("FAIL basic_prod: got %h need 008f", resp_prod);
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL basic_latency: got %0d need %0d", lat, exp_lat);
        end
        n_cmp++;
        if (adds !== exp_adds) begin
            n_err++;
            $display("FAIL basic_add_cycles: got %0d need %0d", adds, exp_adds);
        end
        tick();
    endtask

    task automatic test_max();
        int lat, adds, car;
        resp_ready = 1'b1;
        run_op(8'd255, 8'd255, lat, adds, car);
        n_cmp++;
        if (resp_prod !== 16'hFE01) begin
            n_err++;
            $display("FAIL max_prod: got %h need fe01", resp_prod);
        end
        n_cmp++;
        if (car < 2) begin
            n_err++;
            $display("FAIL max_carries: got %0d need >=2", car);
        end
        n_cmp++;
        if (lat !== 9) begin
            n_err++;
            $display("FAIL max_latency: got %0d need 9", lat);
        end
        tick();
    endtask

    task automatic test_early_exit();
        int lat, adds, car;
        int exp1, exp0;
`ifdef MULSEQ_EARLY_EXIT_EN
        exp1 = 3; exp0 = 2;
`else
        exp1 = 9; exp0 = 9;
`endif
        resp_ready = 1'b1;
        run_op(8'd200, 8'd1, lat, adds, car);
        n_cmp++;
        if (resp_prod !== 16'h00C8) begin
            n_err++;
            $display("FAIL x1_prod: got %h need 00c8", resp_prod);
        end
        n_cmp++;
        if (lat !== exp1) begin
            n_err++;
            $display("FAIL x1_latency: got %0d need %0d", lat, exp1);
        end
        tick();
        run_op(8'd7, 8'd0, lat, adds, car);
        n_cmp++;
        if (resp_prod !== 16'h0000) begin
            n_err++;
            $display("FAIL x0_prod: got %h need 0000", resp_prod);
        end
        n_cmp++;
        if (lat !== exp0) begin
            n_err++;
            $display("FAIL x0_latency: got %0d need %0d", lat, exp0);
        end
        tick();
    endtask

    task automatic test_hold();
        int lat, adds, car;
        resp_ready = 1'b0;
        run_op(8'd13, 8'd11, lat, adds, car);
        req_a     = 8'd9;
        req_b     = 8'd9;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({resp_valid, req_ready, resp_prod} !== {1'b1, 1'b0, 16'h008F}) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b prod=%h need 1 0 008f",
                         i, resp_valid, req_ready, resp_prod);
            end
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        n_cmp++;
        if (resp_prod !== 16'h008F) begin
            n_err++;
            $display("FAIL hold_release_prod: got %h need 008f", resp_prod);
        end
        tick();
        n_cmp++;
        if ({resp_valid, req_ready, alu_busy} !== 3'b010) begin
            n_err++;
            $display("FAIL hold_after: got vld=%b rdy=%b busy=%b need 0 1 0",
                     resp_valid, req_ready, alu_busy);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, adds, car;
        resp_ready = 1'b1;
        req_a      = 8'd13;
        req_b      = 8'd11;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (alu_busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_busy: got %b need 1", alu_busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, alu_busy, alu_sel, resp_prod}
            !== {1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000}) begin
            n_err++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b sel=%b prod=%h need 1 0 0 0000 0000",
                     req_ready, resp_valid, alu_busy, alu_sel, resp_prod);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op(8'd3, 8'd5, lat, adds, car);
        n_cmp++;
        if (resp_prod !== 16'h000F) begin
            n_err++;
            $display("FAIL post_reset_prod: got %h need 000f", resp_prod);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, adds, car;
        int wait_cyc;
        resp_ready = 1'b1;
        run_op(8'd2, 8'd3, lat, adds, car);
        n_cmp++;
        if (resp_prod !== 16'h0006) begin
            n_err++;
            $display("FAIL b2b_first: got %h need 0006", resp_prod);
        end
        req_a     = 8'd4;
        req_b     = 8'd5;
        req_valid = 1'b1;
        tick();
        n_cmp++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_bubble: got rdy=%b vld=%b need 1 0", req_ready, resp_valid);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if ({req_ready, alu_busy} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_accept: got rdy=%b busy=%b need 0 1", req_ready, alu_busy);
        end
        wait_cyc = 0;
        while (!resp_valid && wait_cyc < 40) begin
            tick();
            wait_cyc++;
        end
        n_cmp++;
        if (resp_prod !== 16'h0014 || !resp_valid) begin
            n_err++;
            $display("FAIL b2b_second: got vld=%b prod=%h need 1 0014", resp_valid, resp_prod);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_early_exit();
        test_hold();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
